// File: rtl/requant_leaky_32.sv
// Requantisation stage behind the 32x32 MAC array. It captures one tile of 32 accumulators,
// then streams one INT8 result per channel: bias add, optional leaky ReLU, rescale, saturate.
module requant_leaky_32 #(
  parameter int N_CH    = 32,
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_CH*ACC_W-1:0] acc_in_flat,
  input  logic [N_CH*ACC_W-1:0] bias_in_flat,
  input  logic [SCALE_W-1:0]    scale,
  input  logic [4:0]            shift,
  input  logic                  leaky_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [4:0]            out_ch,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CH_W = 5;
  localparam int M_W  = ACC_W + SCALE_W;
  localparam logic [CH_W-1:0]      LAST_CH = CH_W'(N_CH - 1);
  localparam logic signed [M_W:0]  RND_ONE = (M_W+1)'(2'sd1);
  localparam logic signed [M_W:0]  SAT_HI  = (M_W+1)'(8'sd127);
  localparam logic signed [M_W:0]  SAT_LO  = (M_W+1)'(8'sh80);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            cnt_q, cnt_d;
  logic [N_CH-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [N_CH-1:0][ACC_W-1:0] bias_q, bias_d;
  logic [SCALE_W-1:0]         scale_q, scale_d;
  logic [4:0]                 shift_q, shift_d;
  logic                       leaky_q, leaky_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       s1_valid_q, s1_valid_d;
  logic signed [ACC_W-1:0]    s1_v_q, s1_v_d;
  logic [CH_W-1:0]            s1_ch_q, s1_ch_d;
  logic                       s2_valid_q, s2_valid_d;
  logic signed [M_W-1:0]      s2_m_q, s2_m_d;
  logic [CH_W-1:0]            s2_ch_q, s2_ch_d;
  logic                       out_valid_q, out_valid_d;
  logic [7:0]                 out_data_q, out_data_d;
  logic [CH_W-1:0]            out_ch_q, out_ch_d;
  logic                       out_last_q, out_last_d;

  logic                       stall_s;
  logic                       issue_s;
  logic                       last_hs_s;

  // Negative inputs take a 13/128 slope; the >>> gives floor rounding.
  function automatic logic signed [ACC_W-1:0] leaky_f(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W+3:0] p;
    p = (ACC_W+4)'(v) * (ACC_W+4)'(5'sd13);
    return ACC_W'(p >>> 7);
  endfunction

  function automatic logic signed [ACC_W-1:0] s1_f(input logic [ACC_W-1:0] acc,
                                                    input logic [ACC_W-1:0] bias,
                                                    input logic             lk);
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] res;
    sum = acc + bias;
    if (lk && sum[ACC_W-1]) begin
      res = leaky_f(sum);
    end else begin
      res = sum;
    end
    return res;
  endfunction

  // Round half up: add half an LSB of the result before the arithmetic shift.
  function automatic logic signed [M_W:0] round_shift_f(input logic signed [M_W-1:0] m,
                                                        input logic [4:0]            sh);
    logic signed [M_W:0] r;
    logic signed [M_W:0] rnd;
    r = (M_W+1)'(m);
    if (sh == 5'd0) begin
      rnd = '0;
    end else begin
      rnd = RND_ONE << (sh - 5'd1);
    end
    return (r + rnd) >>> sh;
  endfunction

  function automatic logic [7:0] sat_f(input logic signed [M_W:0] r);
    logic [7:0] res;
    if (r > SAT_HI) begin
      res = 8'h7f;
    end else if (r < SAT_LO) begin
      res = 8'h80;
    end else begin
      res = 8'(r);
    end
    return res;
  endfunction

  assign stall_s   = out_valid_q & ~out_ready;
  assign last_hs_s = out_valid_q & out_ready & out_last_q;

  // Control FSM: tile capture, in-order channel issue, completion on the last handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bias_d  = bias_q;
    scale_d = scale_q;
    shift_d = shift_q;
    leaky_d = leaky_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = acc_in_flat;
          bias_d  = bias_in_flat;
          scale_d = scale;
          shift_d = shift;
          leaky_d = leaky_en;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!stall_s) begin
          issue_s = 1'b1;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == LAST_CH) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (last_hs_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: all three stages advance together and freeze as one under backpressure.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_v_d      = s1_v_q;
    s1_ch_d     = s1_ch_q;
    s2_valid_d  = s2_valid_q;
    s2_m_d      = s2_m_q;
    s2_ch_d     = s2_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    if (!stall_s) begin
      s1_valid_d = issue_s;
      if (issue_s) begin
        s1_v_d  = s1_f(acc_q[cnt_q], bias_q[cnt_q], leaky_q);
        s1_ch_d = cnt_q;
      end else begin
        s1_ch_d = s1_ch_q;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_m_d  = M_W'(s1_v_q) * $signed({{(M_W-SCALE_W){1'b0}}, scale_q});
        s2_ch_d = s1_ch_q;
      end else begin
        s2_ch_d = s2_ch_q;
      end
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_data_d = sat_f(round_shift_f(s2_m_q, shift_q));
        out_ch_d   = s2_ch_q;
        out_last_d = (s2_ch_q == LAST_CH);
      end else begin
        out_ch_d   = out_ch_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State, capture and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      leaky_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_v_q      <= '0;
      s1_ch_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_m_q      <= '0;
      s2_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      scale_q     <= scale_d;
      shift_q     <= shift_d;
      leaky_q     <= leaky_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_v_q      <= s1_v_d;
      s1_ch_q     <= s1_ch_d;
      s2_valid_q  <= s2_valid_d;
      s2_m_q      <= s2_m_d;
      s2_ch_q     <= s2_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_requant_leaky_32.sv
// Self-checking bench for requant_leaky_32: hand-derived vector tables plus random tiles
// checked against an arithmetic model, with backpressure, spurious start and mid-tile reset.
module tb_requant_leaky_32;

  logic          clk = 1'b0;
  logic          rst_n, start, leaky_en, out_ready;
  logic [1023:0] acc_in_flat, bias_in_flat;
  logic [15:0]   scale;
  logic [4:0]    shift;
  logic          out_valid, out_last, busy, done;
  logic [7:0]    out_data;
  logic [4:0]    out_ch;

  requant_leaky_32 dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .acc_in_flat(acc_in_flat), .bias_in_flat(bias_in_flat),
    .scale(scale), .shift(shift), .leaky_en(leaky_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int tile; int ch; int acc; int bias; int exp; } vec_t;
  typedef struct { int scale; int shift; bit leaky; } cfg_t;

  int n_vec = 0;
  int n_err = 0;
  int t_acc [32];
  int t_bias [32];
  int t_exp [32];
  int t_scale, t_shift;
  bit t_leaky;
  int rdy_mode, hold_ch, spur_ch;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floordiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: plain integer arithmetic on the stated rules.
  function automatic int model(input int acc, input int bias, input int sc, input int sh, input bit lk);
    int s32;
    longint v, m, r, d;
    s32 = acc + bias;
    v = s32;
    if (lk && v < 0) v = floordiv(v * 13, 128);
    m = v * sc;
    if (sh == 0) r = m;
    else begin
      d = longint'(1) << sh;
      r = floordiv(m + d / 2, d);
    end
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic load_inputs();
    for (int c = 0; c < 32; c++) begin
      acc_in_flat[c*32 +: 32]  = t_acc[c];
      bias_in_flat[c*32 +: 32] = t_bias[c];
    end
    scale    = t_scale[15:0];
    shift    = t_shift[4:0];
    leaky_en = t_leaky;
  endtask

  task automatic scramble();
    for (int c = 0; c < 32; c++) begin
      acc_in_flat[c*32 +: 32]  = $urandom;
      bias_in_flat[c*32 +: 32] = $urandom;
    end
    scale    = 16'($urandom);
    shift    = 5'($urandom);
    leaky_en = ~t_leaky;
  endtask

  task automatic fill_exp();
    for (int c = 0; c < 32; c++) t_exp[c] = model(t_acc[c], t_bias[c], t_scale, t_shift, t_leaky);
  endtask

  task automatic rand_tile();
    t_scale = int'($urandom_range(0, 65535));
    t_shift = int'($urandom_range(6, 22));
    t_leaky = ($urandom_range(0, 1) == 1);
    for (int c = 0; c < 32; c++) begin
      if ($urandom_range(0, 7) == 0) t_acc[c] = int'($urandom);
      else t_acc[c] = int'($urandom_range(0, 8000)) - 4000;
      t_bias[c] = int'($urandom_range(0, 400)) - 200;
    end
    fill_exp();
  endtask

  task automatic run_tile(input string tag);
    int k, nexp, first_k, last_k, hold_cnt;
    bit hold_done, spur_done, prev_stall, ov, rdy, early_done;
    logic [7:0] p_data;
    logic [4:0] p_ch;
    logic p_last;
    k = 0; nexp = 0; first_k = -1; last_k = -1; hold_cnt = 0;
    hold_done = 0; spur_done = 0; prev_stall = 0; early_done = 0;
    p_data = '0; p_ch = '0; p_last = 1'b0;
    @(negedge clk);
    load_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    chk({tag, " busy after start"}, busy, 1);
    while (nexp < 32 && k < 600) begin
      ov = out_valid;
      if (start) start = 1'b0;
      if (done) early_done = 1;
      if (prev_stall)
        chk({tag, " held output"}, {ov, out_last, out_ch, out_data}, {1'b1, p_last, p_ch, p_data});
      if (ov && first_k < 0) first_k = k;
      if (ov && !hold_done && hold_ch >= 0 && int'(out_ch) == hold_ch) begin
        hold_cnt  = 5;
        hold_done = 1;
      end
      if (hold_cnt > 0) begin
        rdy = 0;
        hold_cnt--;
      end else if (rdy_mode == 0) rdy = 1;
      else rdy = ($urandom_range(0, 1) == 1);
      out_ready = rdy;
      if (ov && !spur_done && spur_ch >= 0 && int'(out_ch) == spur_ch) begin
        start = 1'b1;
        scramble();
        spur_done = 1;
      end
      if (ov && rdy) begin
        chk({tag, " ch"}, out_ch, nexp);
        chk({tag, " data"}, $signed(out_data), t_exp[nexp]);
        chk({tag, " last"}, out_last, (nexp == 31));
        last_k = k;
        nexp++;
      end
      prev_stall = ov && !rdy;
      p_data = out_data; p_ch = out_ch; p_last = out_last;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (nexp < 32) chk({tag, " timeout handshakes"}, nexp, 32);
    chk({tag, " no early done"}, early_done, 0);
    if (rdy_mode == 0 && hold_ch < 0) begin
      chk({tag, " first valid latency"}, first_k, 3);
      chk({tag, " last handshake cycle"}, last_k, 34);
    end
    chk({tag, " done pulse"}, done, 1);
    chk({tag, " busy low with done"}, busy, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    vec_t vecs [16];
    cfg_t cfgs [6];
    bit seen;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    acc_in_flat = '0; bias_in_flat = '0; scale = '0; shift = '0; leaky_en = 1'b0;
    rdy_mode = 0; hold_ch = -1; spur_ch = -1;

    cfgs[0] = '{1, 0, 0};     cfgs[1] = '{1, 0, 1};  cfgs[2] = '{1, 1, 0};
    cfgs[3] = '{3, 4, 0};     cfgs[4] = '{65535, 31, 0};  cfgs[5] = '{1, 0, 1};
    vecs[0]  = '{0, 0, 100, 0, 100};
    vecs[1]  = '{0, 1, 127, 0, 127};
    vecs[2]  = '{0, 2, 200, 0, 127};
    vecs[3]  = '{0, 3, -1000, 0, -128};
    vecs[4]  = '{1, 0, -1000, 0, -102};
    vecs[5]  = '{1, 1, 90, 27, 117};
    vecs[6]  = '{1, 2, -50, 50, 0};
    vecs[7]  = '{2, 0, 5, 0, 3};
    vecs[8]  = '{2, 1, -5, 0, -2};
    vecs[9]  = '{3, 0, 40, 0, 8};
    vecs[10] = '{4, 0, 2147483647, 0, 127};
    vecs[11] = '{4, 1, 2147483647, 1, -128};
    vecs[12] = '{4, 2, -3, 0, 0};
    vecs[13] = '{5, 0, -1, 0, -1};
    vecs[14] = '{5, 1, -128, 0, -13};
    vecs[15] = '{5, 2, 2147483647, 1, -128};

    repeat (2) @(negedge clk);
    chk("reset outputs", {out_valid, out_data, out_ch, out_last, busy, done}, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      t_scale = cfgs[t].scale;
      t_shift = cfgs[t].shift;
      t_leaky = cfgs[t].leaky;
      for (int c = 0; c < 32; c++) begin
        t_acc[c]  = int'($urandom_range(0, 600)) - 300;
        t_bias[c] = int'($urandom_range(0, 100)) - 50;
      end
      for (int i = 0; i < 16; i++) begin
        if (vecs[i].tile == t) begin
          t_acc[vecs[i].ch]  = vecs[i].acc;
          t_bias[vecs[i].ch] = vecs[i].bias;
        end
      end
      fill_exp();
      for (int i = 0; i < 16; i++) begin
        if (vecs[i].tile == t) t_exp[vecs[i].ch] = vecs[i].exp;
      end
      rdy_mode = 0; hold_ch = -1; spur_ch = -1;
      run_tile($sformatf("vec%0d", t));
    end

    for (int t = 0; t < 5; t++) begin
      rand_tile();
      rdy_mode = (t == 4) ? 0 : 1;
      hold_ch  = (t == 0) ? 7 : -1;
      spur_ch  = (t == 1 || t == 4) ? 10 : -1;
      run_tile($sformatf("rand%0d", t));
    end

    // Reset in the middle of a streaming tile.
    rand_tile();
    @(negedge clk);
    load_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("midtile streaming", {busy, out_valid}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("midtile reset outputs", {out_valid, out_data, out_ch, out_last, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || out_valid || busy) seen = 1;
    end
    chk("no activity after reset", seen, 0);

    rand_tile();
    rdy_mode = 0; hold_ch = -1; spur_ch = -1;
    run_tile("fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/requant_leaky_32.md
Name: requant_leaky_32

Overview:
- Post-processing stage directly downstream of the 32x32 MAC array.
- Captures the 32 packed 32-bit accumulators of a finished Cout tile, then processes one channel per cycle: bias add, optional leaky ReLU, fixed-point rescale with rounding, INT8 saturation.
- Emits the INT8 results serially over a valid/ready stream toward the output buffer / writeback.

Parameters:
- N_CH, 32, number of channels per tile (accumulators captured per start).
- ACC_W, 32, accumulator and bias width (signed).
- SCALE_W, 16, requant multiplier width (unsigned).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  capture pulse; accepted only in IDLE.
- acc_in_flat  input  N_CH*ACC_W  packed accumulators; [c*32+:32] = channel c, signed.
- bias_in_flat  input  N_CH*ACC_W  packed per-channel bias, same packing, signed.
- scale  input  SCALE_W  unsigned multiplier; sampled at accepted start.
- shift  input  5  right-shift amount 0..31; sampled at accepted start.
- leaky_en  input  1  enables leaky ReLU; sampled at accepted start.
- out_valid  output  1  out_data/out_ch/out_last valid.
- out_ready  input  1  downstream accept.
- out_data  output  8  signed INT8 result.
- out_ch  output  5  channel index of out_data.
- out_last  output  1  high with channel N_CH-1.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after last handshake.

Behaviour:
- Reset (async, any state): FSM to IDLE; channel counter and all pipeline valids to 0; out_valid, out_data, out_ch, out_last, busy, done = 0. Reset mid-tile discards the tile; no done pulse.
- FSM IDLE: on start, copy acc_in_flat, bias_in_flat, scale, shift and leaky_en into internal registers; go to RUN; busy = 1 from the next cycle.
- FSM RUN: issue channel 0..N_CH-1 in order, one per unstalled cycle.
- FSM RUN to DRAIN: after channel N_CH-1 is issued.
- FSM DRAIN to IDLE: on the handshake of out_last (out_valid && out_ready). busy falls and done pulses in the cycle after that handshake.
- start while busy: ignored, with no effect on the captured data.
- start in the same cycle done is high: accepted, because the FSM is already in IDLE.
- Stage S1:
  - v = acc[c] + bias[c], 32-bit two's-complement wrap.
  - If leaky_en and v < 0: v = (v * 13) >>> 7, arithmetic floor, i.e. 0.1016 slope.
- Stage S2: m = v * scale, 48-bit signed; scale is zero-extended.
- Stage S3:
  - shift = 0: r = m.
  - shift > 0: r = (m + (1 << (shift-1))) >>> shift, round-half-up.
  - Saturate r to [-128, 127] into out_data.
- Latency: the first out_valid is asserted 3 cycles after the cycle following start acceptance, unless stalled.
- Throughput: 1 channel/cycle when out_ready = 1.
- Backpressure: while out_valid && !out_ready, the whole pipeline and issue counter freeze. out_data, out_ch and out_last stay stable until the handshake. No bubbles are inserted or dropped.
- out_valid must not depend combinationally on out_ready.
- Channels emerge in strictly increasing order 0..N_CH-1, exactly N_CH handshakes per tile.

Test Plan:
- Passthrough/sat: scale = 1, shift = 0, leaky off, bias = 0; acc[0..3] = 100, 127, 200, -1000 -> out_data = 100, 127, 127, -128; out_ch = 0..3.
- Bias + leaky: leaky_en = 1, scale = 1, shift = 0; acc[0] = -1000, bias = 0 -> -102. acc[1] = 90, bias = 27 -> 117. acc[2] = -50, bias = 50 -> 0.
- Rounding: scale = 1, shift = 1; acc = 5 -> 3, acc = -5 -> -2. Then scale = 3, shift = 4, acc = 40 -> 8 (120/16 = 7.5 rounds to 8).
- Streaming: out_ready held 1 -> 32 consecutive out_valid cycles; first one 4 cycles after start. out_last only at ch 31; done pulses 1 cycle after the ch 31 handshake; busy falls with done.
- Backpressure: out_ready toggled randomly, including low for 5 cycles at ch 7 -> ch 7 data held stable; sequence 0..31 complete with no loss or duplication; values match the model.
- Control corners:
  - start pulse at ch 10 of an active tile -> ignored; outputs unchanged.
  - rst_n low mid-tile -> all outputs 0 immediately; no done.
  - New start accepted afterwards -> correct fresh tile.
